// File: rtl/z_core_pkg.sv
// Shared encodings for the Z-Core memory bridge: access sizes, AXI response
// codes, protection attributes and the bridge FSM state type.
package z_core_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] PROT_DATA  = 3'b000;
    localparam logic [2:0] PROT_INSTR = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } zc_state_t;

    // Size 3 is illegal; halves need an even address, words a 4-byte aligned one.
    function automatic logic zc_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/z_core_lsu_align.sv
// Combinational byte-lane steering for the Z-Core bridge: store data
// replication and strobes, load lane extraction with sign/zero extension,
// and the illegal/misaligned request check.
module z_core_lsu_align
    import z_core_pkg::*;
(
    input  logic [1:0]  i_wr_size,
    input  logic [1:0]  i_wr_off,
    input  logic [31:0] i_wr_data,
    output logic [31:0] o_wr_data,
    output logic [3:0]  o_wr_strb,
    output logic        o_misaligned,
    input  logic [1:0]  i_rd_size,
    input  logic [1:0]  i_rd_off,
    input  logic        i_rd_unsigned,
    input  logic        i_rd_instr,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_rd_data
);

    logic [31:0] w_rd_shift;

    // Move the addressed lane down to bit 0 before extension.
    assign w_rd_shift   = i_rd_data >> {i_rd_off, 3'b000};
    assign o_misaligned = zc_misaligned(i_wr_size, i_wr_off);

    // Store side: replicate the right-aligned data into every lane and enable the addressed ones.
    always_comb begin
        o_wr_data = i_wr_data;
        o_wr_strb = 4'b1111;
        case (i_wr_size)
            SIZE_B: begin
                o_wr_data = {4{i_wr_data[7:0]}};
                o_wr_strb = 4'b0001 << i_wr_off;
            end
            SIZE_H: begin
                o_wr_data = {2{i_wr_data[15:0]}};
                o_wr_strb = 4'b0011 << i_wr_off;
            end
            default: begin
                o_wr_data = i_wr_data;
                o_wr_strb = 4'b1111;
            end
        endcase
    end

    // Load side: extend the selected lane; instruction fetches always return the whole word.
    always_comb begin
        o_rd_data = i_rd_data;
        if (!i_rd_instr) begin
            case (i_rd_size)
                SIZE_B:  o_rd_data = i_rd_unsigned ? {24'd0, w_rd_shift[7:0]}
                                                   : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
                SIZE_H:  o_rd_data = i_rd_unsigned ? {16'd0, w_rd_shift[15:0]}
                                                   : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
                default: o_rd_data = i_rd_data;
            endcase
        end
    end

endmodule

// File: rtl/z_core_axil_master.sv
// AXI4-Lite master bridge for the multicycle Z-Core. One request at a time
// becomes a single AXI4-Lite read or write; exactly one response per request.
//
// Handshake rules: a transfer on any channel (core request or AXI) happens on
// a rising edge where both valid and ready are high. The bridge's valids and
// readies are registers and never depend combinationally on the opposite
// ready/valid; payload outputs are held constant while their valid is high.
module z_core_axil_master
    import z_core_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic                  req_instr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output zc_state_t             dbg_state,

    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    zc_state_t             r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    // Request attributes still needed once the read data returns.
    logic [1:0]            r_size;
    logic [1:0]            r_off;
    logic                  r_unsigned;
    logic                  r_instr;

    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [2:0]            r_awprot;
    logic                  r_awvalid;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_wvalid;
    logic                  r_bready;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]            r_arprot;
    logic                  r_arvalid;
    logic                  r_rready;

    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_WIDTH-1:0] w_wr_strb;
    logic                  w_misaligned;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    // Store steering and the legality check look at the live request so the
    // decision is made on the accepting edge; load extraction uses the
    // captured attributes against the returning read data.
    z_core_lsu_align u_align (
        .i_wr_size     (req_size),
        .i_wr_off      (req_addr[1:0]),
        .i_wr_data     (req_wdata),
        .o_wr_data     (w_wr_data),
        .o_wr_strb     (w_wr_strb),
        .o_misaligned  (w_misaligned),
        .i_rd_size     (r_size),
        .i_rd_off      (r_off),
        .i_rd_unsigned (r_unsigned),
        .i_rd_instr    (r_instr),
        .i_rd_data     (m_axil_rdata),
        .o_rd_data     (w_rd_data)
    );

    // A write channel is finished once its valid has dropped or handshakes this edge.
    assign w_aw_done   = !r_awvalid || m_axil_awready;
    assign w_w_done    = !r_wvalid  || m_axil_wready;
    assign w_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};

    // Bridge FSM: owns every registered output, including all AXI channel signals.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_size      <= SIZE_W;
            r_off       <= 2'b00;
            r_unsigned  <= 1'b0;
            r_instr     <= 1'b0;
            r_awaddr    <= '0;
            r_awprot    <= PROT_DATA;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_araddr    <= '0;
            r_arprot    <= PROT_DATA;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        r_size      <= req_size;
                        r_off       <= req_addr[1:0];
                        r_unsigned  <= req_unsigned;
                        r_instr     <= req_instr;
                        if (w_misaligned) begin
                            // Rejected locally: nothing reaches the interconnect.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_DONE;
                        end else if (req_we) begin
                            r_awaddr  <= w_word_addr;
                            r_awprot  <= PROT_DATA;
                            r_wdata   <= w_wr_data;
                            r_wstrb   <= w_wr_strb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR;
                        end else begin
                            r_araddr  <= w_word_addr;
                            r_arprot  <= req_instr ? PROT_INSTR : PROT_DATA;
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_WR: begin
                    if (r_awvalid && m_axil_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axil_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (m_axil_bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (m_axil_bresp != AXI_RESP_OKAY);
                        r_rsp_rdata <= '0;
                        r_state     <= ST_DONE;
                    end
                end
                ST_RD_ADDR: begin
                    if (m_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (m_axil_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= (m_axil_rresp != AXI_RESP_OKAY);
                        r_rsp_rdata <= (m_axil_rresp != AXI_RESP_OKAY) ? '0 : w_rd_data;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready      = r_req_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_err        = r_rsp_err;
    assign rsp_rdata      = r_rsp_rdata;
    assign dbg_state      = r_state;

    assign m_axil_awaddr  = r_awaddr;
    assign m_axil_awprot  = r_awprot;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wdata;
    assign m_axil_wstrb   = r_wstrb;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_araddr;
    assign m_axil_arprot  = r_arprot;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_z_core_axil_master.sv
// Bench for z_core_axil_master: a wait-configurable AXI4-Lite slave model,
// a request driver that measures response latency and channel activity,
// and a response scoreboard fed from an expected queue.
module tb_z_core_axil_master;
  import z_core_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, req_instr, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  zc_state_t   dbg_state;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  z_core_axil_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_instr(req_instr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dbg_state(dbg_state),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- slave model ----------------
  int          cfg_aww = 0, cfg_ww = 0, cfg_bw = 0, cfg_arw = 0, cfg_rw = 0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_resp = 2'b00;
  int          aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          aw_seen = 0, w_seen = 0, ar_seen = 0;
  logic [31:0] rec_awaddr, rec_wdata, rec_araddr;
  logic [2:0]  rec_awprot, rec_arprot;
  logic [3:0]  rec_wstrb;

  initial begin
    int cnt;
    awready = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin awready = 0; cnt = 0; end
      else if (awready) begin awready = 0; aw_hs++; cnt = 0; end
      else if (awvalid) begin
        if (cnt >= cfg_aww) begin awready = 1; rec_awaddr = awaddr; rec_awprot = awprot; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    wready = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin wready = 0; cnt = 0; end
      else if (wready) begin wready = 0; w_hs++; cnt = 0; end
      else if (wvalid) begin
        if (cnt >= cfg_ww) begin wready = 1; rec_wdata = wdata; rec_wstrb = wstrb; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    arready = 0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin arready = 0; cnt = 0; end
      else if (arready) begin arready = 0; ar_hs++; cnt = 0; end
      else if (arvalid) begin
        if (cnt >= cfg_arw) begin arready = 1; rec_araddr = araddr; rec_arprot = arprot; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    bvalid = 0; bresp = 2'b00; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin bvalid = 0; cnt = 0; end
      else if (bvalid) begin bvalid = 0; cnt = 0; end
      else if (bready) begin
        if (cnt >= cfg_bw) begin bvalid = 1; bresp = cfg_resp; end
        else cnt++;
      end else cnt = 0;
    end
  end

  initial begin
    int cnt;
    rvalid = 0; rresp = 2'b00; rdata = '0; cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin rvalid = 0; cnt = 0; end
      else if (rvalid) begin rvalid = 0; cnt = 0; end
      else if (rready) begin
        if (cnt >= cfg_rw) begin rvalid = 1; rresp = cfg_resp; rdata = cfg_rdata; end
        else cnt++;
      end else cnt = 0;
    end
  end

  // Cycles in which each request-side valid was observed high.
  initial begin
    forever begin
      @(negedge clk);
      if (awvalid) aw_seen++;
      if (wvalid)  w_seen++;
      if (arvalid) ar_seen++;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic model_bad(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return off[0];
    if (size == 2'd2) return off != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns, input logic instr);
    logic [7:0]  b;
    logic [15:0] h;
    if (instr || size == 2'd2) return d;
    case (off)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    if (size == 2'd0) return uns ? {24'h0, b} : {{24{b[7]}}, b};
    return uns ? {16'h0, h} : {{16{h[15]}}, h};
  endfunction

  function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [1:0] off);
    if (size == 2'd2) return 4'b1111;
    if (size == 2'd1) return off[1] ? 4'b1100 : 4'b0011;
    case (off)
      2'd0: return 4'b0001;
      2'd1: return 4'b0010;
      2'd2: return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (size == 2'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // ---------------- scoreboard ----------------
  logic [32:0] exp_q[$];

  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
          check_eq("rsp_rdata", rsp_rdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic instr, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdv, input logic [1:0] resp,
                        input int aww, input int ww, input int bw, input int arw, input int rw);
    logic bad, exp_err, got;
    logic [31:0] exp_data;
    int exp_lat, lat, waited;
    int aw_hs0, w_hs0, ar_hs0, aw_s0, w_s0, ar_s0;
    bad = model_bad(size, addr[1:0]);
    exp_err  = bad || (resp != 2'b00);
    exp_data = (exp_err || we) ? 32'd0 : model_load(rdv, size, addr[1:0], uns, instr);
    if (bad) exp_lat = 1;
    else if (we) exp_lat = 3 + ((aww > ww) ? aww : ww) + bw;
    else exp_lat = 3 + arw + rw;
    cfg_aww = aww; cfg_ww = ww; cfg_bw = bw; cfg_arw = arw; cfg_rw = rw;
    cfg_rdata = rdv; cfg_resp = resp;

    @(negedge clk);
    waited = 0;
    while (!req_ready && waited < 50) begin @(negedge clk); waited++; end
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    aw_hs0 = aw_hs; w_hs0 = w_hs; ar_hs0 = ar_hs;
    aw_s0 = aw_seen; w_s0 = w_seen; ar_s0 = ar_seen;
    req_we = we; req_instr = instr; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    exp_q.push_back({exp_err, exp_data});
    @(posedge clk);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (lat == 1) check_eq("req_ready_busy", {31'd0, req_ready}, 32'd0);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    check_eq("rsp_seen", {31'd0, got}, 32'd1);
    if (got) begin
      check_eq("latency", lat, exp_lat);
      @(negedge clk);
      check_eq("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    end
    if (bad) begin
      check_eq("bad_aw_seen", aw_seen - aw_s0, 0);
      check_eq("bad_w_seen",  w_seen - w_s0, 0);
      check_eq("bad_ar_seen", ar_seen - ar_s0, 0);
    end else if (we) begin
      check_eq("aw_hs", aw_hs - aw_hs0, 1);
      check_eq("w_hs",  w_hs - w_hs0, 1);
      check_eq("wr_ar_seen", ar_seen - ar_s0, 0);
      check_eq("awaddr", rec_awaddr, {addr[31:2], 2'b00});
      check_eq("awprot", {29'd0, rec_awprot}, 32'd0);
      check_eq("wdata", rec_wdata, model_wdata(size, wd));
      check_eq("wstrb", {28'd0, rec_wstrb}, {28'd0, model_strb(size, addr[1:0])});
    end else begin
      check_eq("ar_hs", ar_hs - ar_hs0, 1);
      check_eq("rd_aw_seen", aw_seen - aw_s0, 0);
      check_eq("araddr", rec_araddr, {addr[31:2], 2'b00});
      check_eq("arprot", {29'd0, rec_arprot}, instr ? 32'd4 : 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        r_we, r_instr, r_uns;
    logic [1:0]  r_size, r_resp;
    logic [31:0] r_addr;
    int          sel, waited;
    req_valid = 0; req_we = 0; req_instr = 0; req_size = 0; req_unsigned = 0;
    req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    check_eq("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check_eq("rst_awaddr", awaddr, 32'd0);
    check_eq("rst_araddr", araddr, 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    check_eq("rst_wstrb_prot", {22'd0, wstrb, awprot, arprot}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;

    // Word fetch, zero-wait slave.
    do_req(0, 1, 2'd2, 0, 32'h0000_0010, 0, 32'h0000_0013, 2'b00, 0, 0, 0, 0, 0);
    // Byte loads, signed and unsigned.
    do_req(0, 0, 2'd0, 0, 32'h0000_0103, 0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0);
    do_req(0, 0, 2'd0, 1, 32'h0000_0103, 0, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0);
    // Half store with W accepted two cycles after AW.
    do_req(1, 0, 2'd1, 0, 32'h0000_0202, 32'h0000_BEEF, 0, 2'b00, 0, 2, 0, 0, 0);
    // W accepted before AW, plus a B stall.
    do_req(1, 0, 2'd0, 0, 32'h0000_0301, 32'h0000_00A5, 0, 2'b00, 3, 0, 1, 0, 0);
    // Misaligned word store.
    do_req(1, 0, 2'd2, 0, 32'h0000_1001, 32'h1234_5678, 0, 2'b00, 0, 0, 0, 0, 0);
    // Word load with SLVERR.
    do_req(0, 0, 2'd2, 0, 32'h0000_0400, 0, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 0, 0);
    // Signed half load from upper lane with AR and R stalls.
    do_req(0, 0, 2'd1, 0, 32'h0000_0502, 0, 32'h8001_7FFF, 2'b00, 0, 0, 0, 1, 2);

    // Reset while waiting for read data.
    cfg_rw = 50; cfg_arw = 0; cfg_resp = 2'b00;
    @(negedge clk);
    req_we = 0; req_instr = 0; req_size = 2'd2; req_unsigned = 0;
    req_addr = 32'h0000_0040; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    waited = 0;
    while (!rready && waited < 20) begin @(negedge clk); waited++; end
    check_eq("abort_in_rd_data", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_arvalid", {31'd0, arvalid}, 32'd0);
    check_eq("abort_rready", {31'd0, rready}, 32'd0);
    check_eq("abort_req_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    do_req(0, 0, 2'd2, 0, 32'h0000_0044, 0, 32'hCAFE_F00D, 2'b00, 0, 0, 0, 0, 0);

    // Randomised mix of loads, stores, fetches, errors and stalls.
    for (int n = 0; n < 24; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_instr = 1'b0;
      r_size  = 2'($urandom_range(0, 3));
      r_uns   = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      if (!r_we && $urandom_range(0, 3) == 0) begin
        r_instr = 1'b1; r_size = 2'd2; r_addr[1:0] = 2'b00;
      end
      sel = $urandom_range(0, 5);
      r_resp = (sel < 4) ? 2'b00 : ((sel == 4) ? 2'b10 : 2'b11);
      do_req(r_we, r_instr, r_size, r_uns, r_addr, $urandom, $urandom, r_resp,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
